// File: rtl/hazard_pkg.sv
// Shared encodings and constants for the pipeline hazard controller.
// The FSM state type is used by hazard_fpu_timer.
package hazard_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int FPU_OP_WIDTH_DEF = 6;
    localparam int FPU_MULTI_BIT    = FPU_OP_WIDTH_DEF - 1;
    localparam int ZERO_REG         = 0;

    // The top bit of the FPU opcode marks a multi-cycle operation.
    function automatic int fpu_multi_bit(input int op_width);
        return op_width - 1;
    endfunction

endpackage

// File: rtl/hazard_fpu_timer.sv
// FPU front-end hold timer: IDLE/BUSY FSM with a countdown. A start in IDLE
// stalls for FPU_LAT-1 cycles in total; busy is the decoded state register.
module hazard_fpu_timer
    import hazard_pkg::*;
#(
    parameter int FPU_LAT   = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic hold,
    output logic busy
);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The op is only sampled in IDLE, so the instruction still sitting in EX
    // on the final BUSY cycle cannot retrigger the timer.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && (FPU_LAT > 1)) begin
                    hold      = 1'b1;
                    state_nxt = ST_BUSY;
                    cnt_nxt   = CNT_WIDTH'(FPU_LAT - 2);
                end
            end
            ST_BUSY: begin
                if (cnt != '0) begin
                    hold    = 1'b1;
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, EX redirect flushes and
// multi-cycle FPU holds. Optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REGFILE_LEN  = 6,
    parameter int FPU_OP_WIDTH = 6,
    parameter int FPU_LAT      = 4,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REGFILE_LEN-1:0]  id_rs1,
    input  logic [REGFILE_LEN-1:0]  id_rs2,
    input  logic                    id_use_rs1,
    input  logic                    id_use_rs2,
    input  logic [REGFILE_LEN-1:0]  ex_rd,
    input  logic                    ex_reg_write,
    input  logic                    ex_mem_read,
    input  logic                    ex_alu_fpu,
    input  logic [FPU_OP_WIDTH-1:0] ex_fpu_op,
    input  logic                    ex_redirect,
    output logic                    pc_stall,
    output logic                    if_id_stall,
    output logic                    if_id_flush,
    output logic                    id_ex_stall,
    output logic                    id_ex_flush,
    output logic                    ex_mem_bubble,
`ifdef HAZARD_PERF_EN
    output logic [31:0]             perf_stall_cycles,
    output logic [31:0]             perf_flushes,
    output logic [31:0]             perf_load_use,
`endif
    output logic                    fpu_busy
);

    localparam int MULTI_BIT = fpu_multi_bit(FPU_OP_WIDTH);

    logic multi;
    logic load_use;
    logic fpu_hold;
    logic lu_bubble;
    logic unused_fpu_op;

    assign multi    = ex_alu_fpu & ex_fpu_op[MULTI_BIT];
    assign load_use = ex_mem_read & ex_reg_write
                    & (ex_rd != REGFILE_LEN'(ZERO_REG))
                    & ((id_use_rs1 & (id_rs1 == ex_rd))
                     | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign unused_fpu_op = ^ex_fpu_op[MULTI_BIT-1:0];

    hazard_fpu_timer #(
        .FPU_LAT   (FPU_LAT),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fpu_timer (
        .clk   (clk),
        .rst   (rst),
        .start (multi & ~ex_redirect & ~rst),
        .hold  (fpu_hold),
        .busy  (fpu_busy)
    );

    // Priority: rst > redirect > FPU hold > load-use. Load-use waits while
    // BUSY because the front end is frozen and re-evaluates on exit.
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        lu_bubble     = 1'b0;
        if (rst) begin
            lu_bubble = 1'b0;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (fpu_hold) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
        end else if (load_use && !fpu_busy) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            lu_bubble   = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
            perf_load_use     <= '0;
        end else begin
            if (pc_stall && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if (if_id_flush && (perf_flushes != '1))
                perf_flushes <= perf_flushes + 1'b1;
            if (lu_bubble && (perf_load_use != '1))
                perf_load_use <= perf_load_use + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (FPU_LAT=4); perf counters checked when
// HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2;
    logic       ex_reg_write, ex_mem_read, ex_alu_fpu, ex_redirect;
    logic [5:0] ex_fpu_op;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic       ex_mem_bubble, fpu_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flushes, perf_load_use;
`endif

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(
        .REGFILE_LEN  (6),
        .FPU_OP_WIDTH (6),
        .FPU_LAT      (4),
        .CNT_WIDTH    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_alu_fpu    (ex_alu_fpu),
        .ex_fpu_op     (ex_fpu_op),
        .ex_redirect   (ex_redirect),
        .pc_stall      (pc_stall),
        .if_id_stall   (if_id_stall),
        .if_id_flush   (if_id_flush),
        .id_ex_stall   (id_ex_stall),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_bubble (ex_mem_bubble),
`ifdef HAZARD_PERF_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes),
        .perf_load_use     (perf_load_use),
`endif
        .fpu_busy      (fpu_busy)
    );

    always #5 clk = ~clk;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_bubble, fpu_busy}
    function automatic logic [6:0] outs();
        return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                ex_mem_bubble, fpu_busy};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        ex_alu_fpu = 1'b0; ex_fpu_op = '0; ex_redirect = 1'b0;
    endtask

    task automatic set_multi();
        clear_inputs();
        ex_alu_fpu = 1'b1;
        ex_fpu_op  = 6'b100000;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        settle();
        check_eq("reset_outs", 32'(outs()), 32'h0);
        rst = 1'b0;
        tick();

        // load-use through rs2, then the bubble arrives in EX
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 6'd5;
        id_rs2 = 6'd5; id_use_rs2 = 1'b1;
        settle();
        check_eq("load_use", 32'(outs()), 32'(7'b1100100));
        tick();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 6'd0;
        settle();
        check_eq("load_use_bubble", 32'(outs()), 32'h0);
        tick();

        // zero register never hazards
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 6'd0;
        id_rs2 = 6'd0; id_use_rs2 = 1'b1;
        settle();
        check_eq("zero_reg", 32'(outs()), 32'h0);
        tick();

        // multi-cycle FPU: 3 stall cycles, busy on cycles 2-4
        set_multi();
        settle();
        check_eq("fpu_c1", 32'(outs()), 32'(7'b1101010));
        tick();
        settle();
        check_eq("fpu_c2", 32'(outs()), 32'(7'b1101011));
        tick();
        settle();
        check_eq("fpu_c3", 32'(outs()), 32'(7'b1101011));
        tick();
        settle();
        check_eq("fpu_c4", 32'(outs()), 32'(7'b0000001));
        tick();
        clear_inputs();
        settle();
        check_eq("fpu_done", 32'(outs()), 32'h0);
        tick();

        // redirect beats a concurrent load-use
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 6'd9;
        id_rs1 = 6'd9; id_use_rs1 = 1'b1; ex_redirect = 1'b1;
        settle();
        check_eq("redirect", 32'(outs()), 32'(7'b0010100));
        tick();
        clear_inputs();

`ifdef HAZARD_PERF_EN
        check_eq("perf_stall", perf_stall_cycles, 32'd4);
        check_eq("perf_flush", perf_flushes, 32'd1);
        check_eq("perf_lu",    perf_load_use, 32'd1);
`endif

        // reset during the second BUSY cycle
        set_multi();
        settle();
        check_eq("rst_fpu_c1", 32'(outs()), 32'(7'b1101010));
        tick();
        rst = 1'b1;
        settle();
        check_eq("rst_comb_outs", 32'(outs() >> 1), 32'h0);
        tick();
        check_eq("rst_after_edge", 32'(outs()), 32'h0);
        rst = 1'b0;
        settle();
        check_eq("restart_c1", 32'(outs()), 32'(7'b1101010));
        tick();
        settle();
        check_eq("restart_c2", 32'(outs()), 32'(7'b1101011));
        tick();
        settle();
        check_eq("restart_c3", 32'(outs()), 32'(7'b1101011));
        tick();
        settle();
        check_eq("restart_c4", 32'(outs()), 32'(7'b0000001));
        tick();
        clear_inputs();

        // load-use through rs1, and cases that must not hazard
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 6'd33;
        id_rs1 = 6'd33; id_use_rs1 = 1'b1;
        settle();
        check_eq("load_use_rs1", 32'(outs()), 32'(7'b1100100));
        tick();
        id_use_rs1 = 1'b0;
        settle();
        check_eq("no_use_flag", 32'(outs()), 32'h0);
        tick();
        id_use_rs1 = 1'b1; ex_reg_write = 1'b0;
        settle();
        check_eq("no_reg_write", 32'(outs()), 32'h0);
        tick();
        clear_inputs();
        ex_alu_fpu = 1'b1; ex_fpu_op = 6'b011111;
        settle();
        check_eq("single_cycle_fpu", 32'(outs()), 32'h0);
        tick();
        clear_inputs();

`ifdef HAZARD_PERF_EN
        check_eq("perf_stall_post_rst", perf_stall_cycles, 32'd4);
        check_eq("perf_flush_post_rst", perf_flushes, 32'd0);
        check_eq("perf_lu_post_rst",    perf_load_use, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller that drives the stall and flush inputs of the IF/ID and ID/EX pipeline registers.
- Consumes the ID-stage register indices and the EX-stage control outputs from the ID/EX register.
- Detects three conditions:
  - load-use data hazards;
  - EX-resolved control transfers (jal/jalr/taken branch);
  - multi-cycle FPU operations, which hold the front end for a fixed latency.
- Sits beside the decode and execute stages; it is the control-side counterpart of the ID/EX register.

Parameters:
- REGFILE_LEN, 6, register index width (int and fp regfile, 64 entries).
- FPU_OP_WIDTH, 6, width of the FPU opcode field.
- FPU_LAT, 4, total EX cycles for a multi-cycle FPU op; legal range 1..15.
- CNT_WIDTH, 4, FPU countdown width; must hold FPU_LAT-1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- id_rs1  input  REGFILE_LEN  rs1 of the instruction in ID
- id_rs2  input  REGFILE_LEN  rs2 of the instruction in ID
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- ex_rd  input  REGFILE_LEN  rd held in ID/EX
- ex_reg_write  input  1  ID/EX reg_write
- ex_mem_read  input  1  ID/EX mem_read
- ex_alu_fpu  input  1  ID/EX alu_fpu (1 = FPU path)
- ex_fpu_op  input  FPU_OP_WIDTH  ID/EX fpu_op
- ex_redirect  input  1  EX resolved a jump/jalr/taken branch this cycle
- pc_stall  output  1  hold PC
- if_id_stall  output  1  hold IF/ID
- if_id_flush  output  1  clear IF/ID to a NOP
- id_ex_stall  output  1  hold ID/EX
- id_ex_flush  output  1  load a bubble (all controls 0) into ID/EX
- ex_mem_bubble  output  1  EX/MEM captures a bubble this cycle
- fpu_busy  output  1  registered; FSM in BUSY state

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, cnt 0, fpu_busy 0.
  - While rst is high, all combinational outputs are forced to 0.
- FSM states: IDLE, BUSY.
- Predicates, all evaluated combinationally from the current inputs and state:
  - multi = ex_alu_fpu & ex_fpu_op[FPU_OP_WIDTH-1].
  - load_use = ex_mem_read & ex_reg_write & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
  - Index 0 never hazards.
- Priority per cycle: rst > redirect > FPU > load-use.
- IDLE, ex_redirect=1:
  - if_id_flush=1 and id_ex_flush=1; PC is not stalled and loads the target.
  - FSM stays IDLE; multi is ignored; this state is illegal by decode.
- IDLE, multi=1 and FPU_LAT>1:
  - Asserts pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble.
  - Next state BUSY with cnt = FPU_LAT-2.
- BUSY, cnt != 0: same four stalls asserted; cnt decrements.
- BUSY, cnt == 0:
  - All stalls deasserted; the FPU result proceeds to EX/MEM.
  - Next state IDLE.
  - multi is not re-evaluated in BUSY, so the same instruction never retriggers.
- Net cost of a multi-cycle op: exactly FPU_LAT-1 stall cycles.
- FPU_LAT=1: BUSY is never entered and multi-cycle ops have no stall.
- IDLE, load_use=1 (no redirect, no multi):
  - pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly one cycle.
  - The bubble clears ex_mem_read, so the condition self-clears.
- Load-use is suppressed while in BUSY; the front end is frozen and the hazard is re-evaluated on exit.
- ex_redirect while in BUSY is illegal: the redirecting instruction cannot be in EX.
- stall and flush never assert together on the same register.
- rst mid-BUSY: returns to IDLE next edge, cnt cleared.

Optional Feature:
- HAZARD_PERF_EN defined adds three output ports, 32-bit each, cleared on rst, saturating at all-ones:
  - perf_stall_cycles: counts cycles with pc_stall=1.
  - perf_flushes: counts cycles with if_id_flush=1.
  - perf_load_use: counts load-use bubbles.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- hazard_pkg holds:
  - state encoding (ST_IDLE, ST_BUSY);
  - FPU_MULTI_BIT = FPU_OP_WIDTH-1;
  - ZERO_REG = 0.
- One sub-module, hazard_fpu_timer, owns the FSM, the counter and fpu_busy.
  - Input: start; outputs: hold, busy.
- Load-use and redirect decode stay in the top level.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; the next cycle, with bubble inputs, shows all 0.
- Zero register: same as load-use but ex_rd=0 -> no stall, no flush.
- FPU_LAT=4, ex_alu_fpu=1, ex_fpu_op=6'b100000 held -> pc_stall, id_ex_stall and ex_mem_bubble high for 3 cycles, low on the 4th; fpu_busy high for cycles 2-4; the op held another cycle does not retrigger.
- Redirect with concurrent load_use: ex_redirect=1 -> if_id_flush=1, id_ex_flush=1, pc_stall=0 in the same cycle.
- rst asserted during the 2nd BUSY cycle -> all outputs 0 during rst, IDLE afterwards, and a fresh FPU op restarts the full 3-cycle stall.
- With HAZARD_PERF_EN: the scenario sequence above -> perf_stall_cycles=4, perf_flushes=1, perf_load_use=1.
